proc_program_feeder: RTL and testbench

//  Issues a stored program to the 16-bit proc core over its DIN/Run/Done interface.

---
 rtl/proc_program_feeder.sv | 174 +++++++++++++++++
 tb/tb_proc_program_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_program_feeder.sv
// Walks a word-addressed program RAM and feeds each instruction (plus the mvi immediate) to proc over DIN/Run/Done.
// Optional Done watchdog: define DONE_TIMEOUT_EN.
module proc_program_feeder #(
    parameter int unsigned AW        = 4,
    parameter logic [2:0]  MVI_OP    = 3'b001,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [15:0]   LoadData,
    input  logic          Start,
    input  logic          Done,
    input  logic [15:0]   BusWires,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Finished,
    output logic          Error,
    output logic [AW-1:0] PC,
    output logic [7:0]    InstrCount,
    output logic [15:0]   LastResult
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_IMMF, S_IMM, S_WAIT, S_END
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state, state_n;
    logic [15:0]   mem [0:(1<<AW)-1];
    logic [15:0]   rdata;
    logic [AW-1:0] raddr;
    logic [15:0]   instr;
    logic [15:0]   hold;
    logic          fetch_ph;
    logic          is_mvi;
    logic [AW:0]   pc_sum;
    logic          start_run;
    logic          retire;
    logic          set_err;
    logic          timeout_hit;

    assign Busy     = (state != S_IDLE) && (state != S_END);
    assign Run      = (state == S_ISSUE);
    assign Finished = (state == S_END);
    assign is_mvi   = (instr[15:13] == MVI_OP);
    assign pc_sum   = {1'b0, PC} + (is_mvi ? (AW+1)'(2) : (AW+1)'(1));
    assign raddr    = (state == S_IMMF) ? PC + AW'(1) : PC;

    // Program RAM: loads only while idle, registered read port
    always_ff @(posedge Clock) begin
        if (LoadEn && !Busy)
            mem[LoadAddr] <= LoadData;
        rdata <= mem[raddr];
    end

`ifdef DONE_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] tcnt;

    always_ff @(posedge Clock) begin
        if (Reset)
            tcnt <= '0;
        else if (state == S_ISSUE || state == S_IMMF)
            tcnt <= '0;
        else if ((state == S_IMM || state == S_WAIT) && !Done)
            tcnt <= tcnt + TCW'(1);
    end

    assign timeout_hit = (tcnt == TCW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    if (TIMEOUT == 0) begin : g_no_watchdog
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_run = 1'b0;
        retire    = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE, S_END: begin
                if (Start) begin
                    state_n   = S_FETCH;
                    start_run = 1'b1;
                end
            end
            // Two cycles: address goes out, then the registered word is evaluated
            S_FETCH: begin
                if (fetch_ph)
                    state_n = (rdata == HALT_WORD) ? S_END : S_ISSUE;
            end
            S_ISSUE: begin
                if (!is_mvi) begin
                    state_n = S_WAIT;
                end else if (PC == LAST_ADDR) begin
                    state_n = S_END;
                    set_err = 1'b1;
                end else begin
                    state_n = S_IMMF;
                end
            end
            S_IMMF: state_n = S_IMM;
            S_IMM, S_WAIT: begin
                if (Done) begin
                    retire  = 1'b1;
                    state_n = pc_sum[AW] ? S_END : S_FETCH;
                end else if (timeout_hit) begin
                    set_err = 1'b1;
                    state_n = S_END;
                end else begin
                    state_n = S_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        DIN = '0;
        case (state)
            S_ISSUE, S_IMMF: DIN = instr;
            S_IMM:           DIN = rdata;
            S_WAIT:          DIN = hold;
            default:         DIN = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (state == S_FETCH && fetch_ph)
            instr <= rdata;
        if (state == S_ISSUE)
            hold <= instr;
        else if (state == S_IMM)
            hold <= rdata;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_ph   <= 1'b0;
            PC         <= '0;
            InstrCount <= '0;
            LastResult <= '0;
            Error      <= 1'b0;
        end else begin
            fetch_ph <= (state == S_FETCH) ? ~fetch_ph : 1'b0;
            if (start_run) begin
                PC         <= '0;
                InstrCount <= '0;
                Error      <= 1'b0;
            end
            if (set_err)
                Error <= 1'b1;
            if (retire) begin
                LastResult <= BusWires;
                InstrCount <= InstrCount + 8'd1;
                PC         <= pc_sum[AW] ? LAST_ADDR : pc_sum[AW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_proc_program_feeder.sv
// Directed bench for proc_program_feeder: single instr, mvi, full RAM, mid-run reset, truncated mvi, Done watchdog.
module tb_proc_program_feeder;

    logic        Clock = 1'b0;
    logic        Reset, LoadEn, Start, Done;
    logic [3:0]  LoadAddr;
    logic [15:0] LoadData, BusWires;
    logic [15:0] DIN, LastResult;
    logic        Run, Busy, Finished, Error;
    logic [3:0]  PC;
    logic [7:0]  InstrCount;

    int checks = 0;
    int errors = 0;
    int runs   = 0;
    int r0;

    always #5 Clock = ~Clock;

    proc_program_feeder #(.AW(4), .MVI_OP(3'b001), .HALT_WORD(16'hFFFF), .TIMEOUT(64)) dut (
        .Clock(Clock), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Start(Start), .Done(Done), .BusWires(BusWires),
        .DIN(DIN), .Run(Run), .Busy(Busy), .Finished(Finished), .Error(Error),
        .PC(PC), .InstrCount(InstrCount), .LastResult(LastResult)
    );

    always @(negedge Clock) if (Run === 1'b1) runs <= runs + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        step();
        LoadEn = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // From the first FETCH cycle: issue a plain instruction, raise Done during ISSUE
    // (must be ignored there) and retire it in WAIT.
    task automatic plain_instr(input string tag);
        step(); step();
        chk({tag, "_run"}, 32'(Run), 32'd1);
        Done = 1'b1;
        step(); step();
        Done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        Reset = 1'b1; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
        Start = 1'b0; Done = 1'b0; BusWires = '0;
        step(); step();
        Reset = 1'b0;
        chk("rst_din", 32'(DIN), 32'h0);
        chk("rst_run", 32'(Run), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_fin", 32'(Finished), 32'd0);
        chk("rst_err", 32'(Error), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_cnt", 32'(InstrCount), 32'd0);
        chk("rst_last", 32'(LastResult), 32'h0);

        // 1: single plain instruction then HALT
        load(4'd0, 16'h0040);
        load(4'd1, 16'hFFFF);
        r0 = runs;
        pulse_start();
        step(); step();
        chk("t1_run", 32'(Run), 32'd1);
        chk("t1_din_issue", 32'(DIN), 32'h0040);
        chk("t1_busy", 32'(Busy), 32'd1);
        step();
        chk("t1_run_drop", 32'(Run), 32'd0);
        chk("t1_din_wait", 32'(DIN), 32'h0040);
        step();
        Done = 1'b1; BusWires = 16'h0007;
        step();
        Done = 1'b0;
        chk("t1_last", 32'(LastResult), 32'h0007);
        chk("t1_cnt", 32'(InstrCount), 32'd1);
        chk("t1_pc", 32'(PC), 32'd1);
        step(); step();
        chk("t1_fin", 32'(Finished), 32'd1);
        chk("t1_idle_busy", 32'(Busy), 32'd0);
        chk("t1_end_din", 32'(DIN), 32'h0);
        chk("t1_runs", 32'(runs - r0), 32'd1);

        // 2: mvi with Done accepted in IMM
        load(4'd0, 16'h2000);
        load(4'd1, 16'h1234);
        load(4'd2, 16'hFFFF);
        r0 = runs;
        pulse_start();
        step(); step();
        chk("t2_run", 32'(Run), 32'd1);
        chk("t2_din_instr", 32'(DIN), 32'h2000);
        step();
        chk("t2_immf_run", 32'(Run), 32'd0);
        chk("t2_immf_din", 32'(DIN), 32'h2000);
        step();
        chk("t2_imm_din", 32'(DIN), 32'h1234);
        Done = 1'b1; BusWires = 16'hABCD;
        step();
        Done = 1'b0;
        chk("t2_pc", 32'(PC), 32'd2);
        chk("t2_cnt", 32'(InstrCount), 32'd1);
        chk("t2_last", 32'(LastResult), 32'hABCD);
        step(); step();
        chk("t2_fin", 32'(Finished), 32'd1);
        chk("t2_err", 32'(Error), 32'd0);
        chk("t2_runs", 32'(runs - r0), 32'd1);

        // 3: all 16 words plain, no HALT -> saturated PC at END
        for (int i = 0; i < 16; i++) load(4'(i), 16'h0040);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            BusWires = 16'(i + 16'h100);
            plain_instr("t3");
        end
        chk("t3_fin", 32'(Finished), 32'd1);
        chk("t3_pc", 32'(PC), 32'd15);
        chk("t3_cnt", 32'(InstrCount), 32'd16);
        chk("t3_last", 32'(LastResult), 32'h010F);
        chk("t3_busy", 32'(Busy), 32'd0);

        // 4: reset in WAIT of the 2nd instruction; dropped load while busy
        pulse_start();
        plain_instr("t4a");
        step(); step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("t4_run", 32'(Run), 32'd0);
        chk("t4_din", 32'(DIN), 32'h0);
        chk("t4_busy", 32'(Busy), 32'd0);
        chk("t4_fin", 32'(Finished), 32'd0);
        chk("t4_pc", 32'(PC), 32'd0);
        chk("t4_cnt", 32'(InstrCount), 32'd0);
        chk("t4_last", 32'(LastResult), 32'h0);
        pulse_start();
        step(); step();
        chk("t4_rerun", 32'(Run), 32'd1);
        chk("t4_rerun_din", 32'(DIN), 32'h0040);
        step();
        load(4'd1, 16'hFFFF);
        Done = 1'b1;
        step();
        Done = 1'b0;
        plain_instr("t4_dropped_load");
        Reset = 1'b1;
        step();
        Reset = 1'b0;

        // 5: Start+LoadEn together, then mvi at the last address
        load(4'd15, 16'h2005);
        LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 16'h0041;
        pulse_start();
        LoadEn = 1'b0;
        step(); step();
        chk("t5_new_word", 32'(DIN), 32'h0041);
        Done = 1'b1;
        step(); step();
        Done = 1'b0;
        for (int i = 1; i < 15; i++) plain_instr("t5");
        r0 = runs;
        step(); step();
        chk("t5_mvi_run", 32'(Run), 32'd1);
        chk("t5_mvi_din", 32'(DIN), 32'h2005);
        chk("t5_mvi_pc", 32'(PC), 32'd15);
        step();
        chk("t5_err", 32'(Error), 32'd1);
        chk("t5_fin", 32'(Finished), 32'd1);
        chk("t5_cnt", 32'(InstrCount), 32'd15);
        chk("t5_runs", 32'(runs - r0), 32'd1);
        pulse_start();
        chk("t5_restart_err", 32'(Error), 32'd0);
        chk("t5_restart_fin", 32'(Finished), 32'd0);
        chk("t5_restart_busy", 32'(Busy), 32'd1);
        chk("t5_restart_cnt", 32'(InstrCount), 32'd0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;

        // 6: Done never arrives for an mvi
        load(4'd0, 16'h2000);
        load(4'd1, 16'h0001);
        pulse_start();
        step(); step(); step(); step();
        chk("t6_imm_din", 32'(DIN), 32'h0001);
`ifdef DONE_TIMEOUT_EN
        repeat (63) step();
        chk("t6_err_early", 32'(Error), 32'd0);
        chk("t6_busy_early", 32'(Busy), 32'd1);
        step();
        chk("t6_err", 32'(Error), 32'd1);
        chk("t6_fin", 32'(Finished), 32'd1);
        chk("t6_cnt", 32'(InstrCount), 32'd0);
`else
        repeat (1000) step();
        chk("t6_busy", 32'(Busy), 32'd1);
        chk("t6_err", 32'(Error), 32'd0);
        chk("t6_hold_din", 32'(DIN), 32'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
